alu_sequencer: RTL and testbench
================================

// Module: alu_sequencer
// PURPOSE
//  Operand/operation sequencer for the 8-bit ALU lab datapath. It debounces the centre push-button.
//  Each accepted press advances an FSM that latches operand A, then operand B and the opcode from the switches.
//  It then issues a one-cycle start to the ALU, waits for completion and holds the result for the display path.
//  It sits between the board I/O in the top level and the ALU/seven-segment blocks.
// PARAMETERS
//  DATA_W        8          operand/result width
//  OP_W          4          opcode width
//  DEBOUNCE_CYC  1_000_000  cycles a synchronized button level must be stable to be accepted (10 ms @ 100 MHz)
//  DONE_TIMEOUT  255        max cycles spent in WAIT_DONE before ERROR
// PORTS
//  clock        in   1       system clock; all logic on rising edge
//  reset        in   1       synchronous, active-high; clears everything
//  btn_raw      in   1       raw centre button (asynchronous, bouncy)
//  sw_data      in   DATA_W  operand switches
//  sw_op        in   OP_W    opcode switches
//  alu_result   in   DATA_W  ALU result
//  alu_done     in   1       ALU result valid; may be tied 1 for a combinational ALU
//  alu_start    out  1       one-cycle pulse requesting an operation
//  alu_a        out  DATA_W  latched operand A (registered)
//  alu_b        out  DATA_W  latched operand B (registered)
//  alu_op       out  OP_W    latched opcode (registered)
//  result       out  DATA_W  captured result, held until the next capture or reset
//  result_valid out  1       high in SHOW
//  busy         out  1       high in EXEC and WAIT_DONE
//  error        out  1       high in ERROR (ALU timeout)
//  state_code   out  3       current FSM encoding, for LED debug
// BEHAVIOUR
//  Reset: state=WAIT_A. alu_a/alu_b/alu_op/result=0. alu_start, result_valid, busy and error=0.
//    Debounce counter and the sync flops are also 0. Reset applies mid-operation with no exceptions.
//  Button path: 2-FF synchronizer -> stable counter (restarts on any level change).
//    The level is accepted after DEBOUNCE_CYC equal samples.
//    press = 1-cycle pulse on the 0->1 transition of the accepted level.
//    A held button yields exactly one press. Latency from a clean edge to press = 2 + DEBOUNCE_CYC cycles.
//  FSM encodings (package): WAIT_A=0, WAIT_B=1, EXEC=2, WAIT_DONE=3, SHOW=4, ERROR=5.
//   WAIT_A: on press, alu_a<=sw_data and go to WAIT_B.
//   WAIT_B: on press, alu_b<=sw_data and alu_op<=sw_op, then go to EXEC.
//   EXEC: alu_start=1 for this single cycle. Clear the timeout counter. Go to WAIT_DONE unconditionally.
//   WAIT_DONE: if alu_done, result<=alu_result and go to SHOW.
//     Else, if the counter reaches DONE_TIMEOUT, go to ERROR. Else increment the counter.
//     If done and the terminal count coincide, done wins.
//   SHOW: result_valid=1. On press, go to WAIT_A; result keeps its value and result_valid drops.
//   ERROR: error=1 and result is unchanged. On press, go to WAIT_A.
//  Presses in EXEC and WAIT_DONE are discarded; they are not queued.
//  alu_done is sampled only in WAIT_DONE. A done already high in the EXEC cycle is seen on the next cycle.
//    With done tied 1, the result is captured exactly 1 cycle after alu_start.
//  alu_a, alu_b and alu_op are stable from capture until the next capture.
//    Switch changes outside a press have no effect.
//  Unused FSM encodings recover to WAIT_A on the next cycle.
//  All outputs are registered, except busy, result_valid and error, which decode from state.
// STRUCTURE
//  Package alu_seq_pkg: state localparams and the DATA_W/OP_W defaults.
//  Sub-module btn_debounce (sync, stable counter, rising-edge pulse; param DEBOUNCE_CYC).
//    It is reused for btnU if a debounced reset is ever needed.
//  Top of this block: FSM, operand registers, timeout counter.
// TESTING  (use DEBOUNCE_CYC=4 in simulation)
//  1. Reset, then a clean press with sw_data=0x12. Then sw_data=0x34, sw_op=0x1 and press. alu_done tied 1.
//     -> alu_start pulses once. alu_a=0x12, alu_b=0x34, alu_op=1. result=alu_result 1 cycle later. result_valid=1.
//  2. Bounce btn_raw 0/1 every 2 cycles for 20 cycles, then hold it high for 50 cycles.
//     -> exactly one press; state advances by exactly one.
//  3. Hold alu_done=0 after EXEC.
//     -> error=1 after DONE_TIMEOUT+1 cycles in WAIT_DONE. A press returns to WAIT_A. result is unchanged.
//  4. Press repeatedly while busy, with alu_done delayed 10 cycles.
//     -> presses are ignored. The first press after SHOW is entered goes to WAIT_A.
//  5. Assert reset in WAIT_DONE and in SHOW.
//     -> next cycle: state=WAIT_A, all outputs 0, no alu_start.
//  6. Raise alu_done and hit the timeout terminal count in the same cycle.
//     -> SHOW with the result captured; error stays 0.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared FSM state encoding and width defaults for the ALU sequencer
package alu_seq_pkg;
    localparam int DATA_W_DEF = 8;
    localparam int OP_W_DEF = 4;
    typedef enum logic [2:0] {
        WAIT_A    = 3'd0,
        WAIT_B    = 3'd1,
        EXEC      = 3'd2,
        WAIT_DONE = 3'd3,
        SHOW      = 3'd4,
        ERROR     = 3'd5
    } state_t;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronizes a bouncy button, accepts a level after DEBOUNCE_CYC equal samples and pulses on its rise
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_raw,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    logic s0, s1, lvl, hit;
    logic [CW-1:0] cnt;
    assign hit = (s1 != lvl) && (cnt == CW'(DEBOUNCE_CYC - 1));
    always_ff @(posedge clock) begin
        if (reset) begin
            s0    <= 1'b0;
            s1    <= 1'b0;
            lvl   <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            s0    <= btn_raw;
            s1    <= s0;
            cnt   <= (s1 == lvl || hit) ? '0 : cnt + 1'b1;
            lvl   <= hit ? s1 : lvl;
            press <= hit & s1;
        end
    end
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: button-driven operand/opcode latching, ALU start/complete handshake with timeout, result hold
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int OP_W         = OP_W_DEF,
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int DONE_TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              btn_raw,
    input  logic [DATA_W-1:0] sw_data,
    input  logic [OP_W-1:0]   sw_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_done,
    output logic              alu_start,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic              busy,
    output logic              error,
    output logic [2:0]        state_code
);
    localparam int TW = $clog2(DONE_TIMEOUT + 1);
    state_t state, state_nx;
    logic press;
    logic [TW-1:0] tcnt;
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn (
        .clock   (clock),
        .reset   (reset),
        .btn_raw (btn_raw),
        .press   (press)
    );
    always_comb begin
        state_nx = WAIT_A;
        case (state)
            WAIT_A:    state_nx = press ? WAIT_B : WAIT_A;
            WAIT_B:    state_nx = press ? EXEC : WAIT_B;
            EXEC:      state_nx = WAIT_DONE;
            WAIT_DONE: state_nx = alu_done ? SHOW : (tcnt == TW'(DONE_TIMEOUT)) ? ERROR : WAIT_DONE;
            SHOW:      state_nx = press ? WAIT_A : SHOW;
            ERROR:     state_nx = press ? WAIT_A : ERROR;
            default:   state_nx = WAIT_A;
        endcase
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= WAIT_A;
            alu_start <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            result    <= '0;
            tcnt      <= '0;
        end else begin
            state     <= state_nx;
            alu_start <= (state_nx == EXEC);
            tcnt      <= (state == WAIT_DONE) ? tcnt + 1'b1 : '0;
            if (state == WAIT_A && press)
                alu_a <= sw_data;
            if (state == WAIT_B && press) begin
                alu_b  <= sw_data;
                alu_op <= sw_op;
            end
            if (state == WAIT_DONE && alu_done)
                result <= alu_result;
        end
    end
    assign state_code   = state;
    assign busy         = (state == EXEC) || (state == WAIT_DONE);
    assign result_valid = (state == SHOW);
    assign error        = (state == ERROR);
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: randomized press/operation sequences checked against a press-level model of the sequencer
module tb_alu_sequencer;
    localparam int DW = 8;
    localparam int OW = 4;
    logic clock = 1'b0, reset = 1'b1, btn_raw = 1'b0;
    logic [DW-1:0] sw_data = '0, alu_result, alu_a, alu_b, result;
    logic [OW-1:0] sw_op = '0, alu_op;
    logic alu_done, alu_start, result_valid, busy, error;
    logic [2:0] state_code;
    int tests = 0, fails = 0, dly = 0, dcnt = 1023, starts = 0;
    int exp_state = 0, exp_starts = 0;
    logic [DW-1:0] exp_a = '0, exp_b = '0, exp_res = '0;
    logic [OW-1:0] exp_op = '0;

    alu_sequencer #(.DATA_W(DW), .OP_W(OW), .DEBOUNCE_CYC(4), .DONE_TIMEOUT(255)) dut (
        .clock        (clock),
        .reset        (reset),
        .btn_raw      (btn_raw),
        .sw_data      (sw_data),
        .sw_op        (sw_op),
        .alu_result   (alu_result),
        .alu_done     (alu_done),
        .alu_start    (alu_start),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy),
        .error        (error),
        .state_code   (state_code)
    );

    always #5 clock = ~clock;

    function automatic logic [DW-1:0] alu_f(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [OW-1:0] op);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            default: return ~a + DW'(op);
        endcase
    endfunction

    assign alu_result = alu_f(alu_a, alu_b, alu_op);
    assign alu_done = (dcnt >= dly);

    always @(posedge clock) begin
        dcnt <= alu_start ? 0 : (dcnt < 1023 ? dcnt + 1 : dcnt);
        if (alu_start) starts <= starts + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic push(input int hold);
        btn_raw = 1'b1;
        cycles(hold);
        btn_raw = 1'b0;
        cycles(10);
    endtask

    task automatic model_press();
        case (exp_state)
            0: begin
                exp_a = sw_data;
                exp_state = 1;
            end
            1: begin
                exp_b = sw_data;
                exp_op = sw_op;
                exp_starts++;
                exp_state = (dly <= 255) ? 4 : 5;
                if (exp_state == 4) exp_res = alu_f(exp_a, exp_b, exp_op);
            end
            default: exp_state = 0;
        endcase
    endtask

    task automatic check_all();
        chk("state", 32'(state_code), 32'(exp_state));
        chk("alu_a", 32'(alu_a), 32'(exp_a));
        chk("alu_b", 32'(alu_b), 32'(exp_b));
        chk("alu_op", 32'(alu_op), 32'(exp_op));
        chk("result", 32'(result), 32'(exp_res));
        chk("result_valid", 32'(result_valid), 32'(exp_state == 4));
        chk("error", 32'(error), 32'(exp_state == 5));
        chk("busy", 32'(busy), 32'd0);
        chk("start_count", 32'(starts), 32'(exp_starts));
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 400) begin
            @(negedge clock);
            n++;
        end
        chk("idle_bound", 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        btn_raw = 1'b0;
        cycles(1);
        exp_state = 0;
        exp_a = '0;
        exp_b = '0;
        exp_op = '0;
        exp_res = '0;
        chk("rst_start", 32'(alu_start), 32'd0);
        check_all();
        reset = 1'b0;
        cycles(2);
    endtask

    task automatic tx();
        sw_data = DW'($urandom);
        sw_op = OW'($urandom);
        model_press();
        push(10);
        wait_idle();
        sw_data = DW'($urandom);
        sw_op = OW'($urandom);
        check_all();
    endtask

    task automatic bounce();
        for (int i = 0; i < 10; i++) begin
            btn_raw = ~btn_raw;
            cycles(2);
        end
    endtask

    initial begin
        int n;
        do_reset();

        dly = 0;
        sw_data = 8'h12;
        sw_op = 4'h7;
        model_press();
        btn_raw = 1'b1;
        cycles(6);
        chk("latency_pre", 32'(state_code), 32'd0);
        cycles(1);
        chk("latency_post", 32'(state_code), 32'd1);
        cycles(3);
        btn_raw = 1'b0;
        cycles(10);
        sw_data = 8'hff;
        check_all();
        sw_data = 8'h34;
        sw_op = 4'h1;
        model_press();
        btn_raw = 1'b1;
        n = 0;
        while (!alu_start && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("start_seen", 32'(alu_start), 32'd1);
        chk("t1_a", 32'(alu_a), 32'h12);
        chk("t1_b", 32'(alu_b), 32'h34);
        chk("t1_op", 32'(alu_op), 32'h1);
        cycles(1);
        chk("start_pulse", 32'(alu_start), 32'd0);
        chk("t1_wait", 32'(state_code), 32'd3);
        cycles(1);
        chk("t1_result", 32'(result), 32'(alu_f(8'h12, 8'h34, 4'h1)));
        chk("t1_show", 32'(state_code), 32'd4);
        cycles(8);
        btn_raw = 1'b0;
        cycles(10);
        check_all();

        model_press();
        bounce();
        push(50);
        check_all();
        sw_data = 8'h5a;
        model_press();
        bounce();
        push(50);
        check_all();

        dly = 1000;
        tx();
        tx();

        dly = 255;
        tx();
        tx();
        tx();
        dly = 256;
        tx();
        tx();
        tx();

        dly = 100;
        tx();
        model_press();
        push(10);
        chk("busy_during", 32'(busy), 32'd1);
        push(10);
        push(10);
        wait_idle();
        check_all();
        tx();

        dly = 1000;
        tx();
        model_press();
        push(10);
        chk("busy_pre_reset", 32'(busy), 32'd1);
        do_reset();
        dly = 3;
        tx();
        tx();
        do_reset();

        for (int i = 0; i < 20; i++) begin
            case ($urandom_range(0, 5))
                0: dly = 0;
                1: dly = int'($urandom_range(1, 30));
                2: dly = 255;
                3: dly = 256;
                4: dly = int'($urandom_range(257, 300));
                default: dly = int'($urandom_range(200, 260));
            endcase
            tx();
            tx();
            tx();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
